// File: rtl/mdu_if.sv
// mdu_if: E-stage MDU handshake plus multiplier/divider IP bus
interface mdu_if;
    logic        req;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mul_ce;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [31:0] rd_data;
    logic        busy;
    logic        start;
    logic        stall;
    modport slave (
        input  req, op, A, B, mul_p, div_done, div_quot, div_rem,
        output mul_ce, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b,
               rd_data, busy, start, stall
    );
    modport master (
        output req, op, A, B, mul_p, div_done, div_quot, div_rem,
        input  mul_ce, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b,
               rd_data, busy, start, stall
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner sequencing a pipelined multiplier IP and an iterative divider IP
module mdu_ctrl #(
    parameter int MUL_LAT = 5
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, opa, opb;
    logic        sgn;
    logic        idle, is_mul, is_div;
    // Decode the E-stage op and derive issue, IP controls and read data
    always_comb begin
        idle           = state == IDLE;
        is_mul         = bus.op == 4'd1 || bus.op == 4'd2;
        is_div         = bus.op == 4'd3 || bus.op == 4'd4;
        bus.start      = idle && !bus.req && (is_mul || (is_div && bus.B != 32'd0));
        bus.busy       = !idle;
        bus.stall      = bus.start || !idle;
        bus.mul_ce     = (bus.start && is_mul) || state == MUL_WAIT;
        bus.div_start  = bus.start && is_div;
        bus.mul_a      = idle ? bus.A : opa;
        bus.mul_b      = idle ? bus.B : opb;
        bus.mul_signed = idle ? bus.op == 4'd1 : sgn;
        bus.div_a      = idle ? bus.A : opa;
        bus.div_b      = idle ? bus.B : opb;
        bus.div_signed = idle ? bus.op == 4'd3 : sgn;
        bus.rd_data    = bus.op == 4'd5 ? hi : bus.op == 4'd6 ? lo : 32'd0;
    end
    // Issue, wait for the IP result, commit into HI/LO; moves to HI/LO only when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            opa   <= 32'd0;
            opb   <= 32'd0;
            sgn   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa   <= bus.A;
                        opb   <= bus.B;
                        sgn   <= bus.op == 4'd1 || bus.op == 4'd3;
                        cnt   <= 4'(MUL_LAT);
                        state <= is_mul ? MUL_WAIT : DIV_WAIT;
                    end else if (!bus.req && bus.op == 4'd7) begin
                        hi <= bus.A;
                    end else if (!bus.req && bus.op == 4'd8) begin
                        lo <= bus.A;
                    end
                end
                MUL_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        {hi, lo} <= bus.mul_p;
                        state    <= IDLE;
                    end
                end
                DIV_WAIT: begin
                    if (bus.div_done) begin
                        lo    <= bus.div_quot;
                        hi    <= bus.div_rem;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an arithmetic HI/LO model
module tb_mdu_ctrl;
    localparam int MUL_LAT = 5;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stray = 1'b0;
    int          d_dly = 8;
    int          dcnt;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi, m_lo;
    logic [31:0] dq, dr;
    logic [63:0] pipe [MUL_LAT];
    mdu_if bus ();
    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Multiplier IP: MUL_LAT-deep pipeline advancing only when enabled
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= 64'd0;
        end else if (bus.mul_ce) begin
            pipe[0] <= bus.mul_signed ? {{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b}
                                      : {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.mul_p = pipe[MUL_LAT-1];
    // Divider IP: results captured at launch, done pulse d_dly cycles later
    always @(posedge clk) begin
        if (reset) begin
            dcnt <= 0;
        end else if (bus.div_start) begin
            dcnt <= d_dly;
            if (bus.div_signed) begin
                dq <= 32'($signed(bus.div_a) / $signed(bus.div_b));
                dr <= 32'($signed(bus.div_a) % $signed(bus.div_b));
            end else begin
                dq <= bus.div_a / bus.div_b;
                dr <= bus.div_a % bus.div_b;
            end
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign bus.div_done = dcnt == 1 || stray;
    assign bus.div_quot = dq;
    assign bus.div_rem  = dr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
        logic        s;
        int          lat, cyc;
        logic [63:0] res;
        logic [3:0]  junk [6];
        junk = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        lat = 0;
        res = 64'd0;
        @(negedge clk);
        bus.req = r; bus.op = o; bus.A = a; bus.B = b;
        #1;
        s = !r && o >= 4'd1 && o <= 4'd4 && !(o >= 4'd3 && b == 32'd0);
        chk("start", 64'(bus.start), 64'(s));
        chk("stall", 64'(bus.stall), 64'(s));
        chk("mul_ce", 64'(bus.mul_ce), 64'(s && o <= 4'd2));
        chk("div_start", 64'(bus.div_start), 64'(s && o >= 4'd3));
        chk("rd_data", 64'(bus.rd_data), 64'(o == 4'd5 ? m_hi : o == 4'd6 ? m_lo : 32'd0));
        if (s && o <= 4'd2) begin
            lat = MUL_LAT;
            res = o == 4'd1 ? longint'($signed(a)) * longint'($signed(b)) : {32'd0, a} * {32'd0, b};
        end else if (s) begin
            lat = d_dly;
            res = o == 4'd3 ? {$signed(a) % $signed(b), $signed(a) / $signed(b)} : {a % b, a / b};
        end
        if (!r && o == 4'd7) m_hi = a;
        if (!r && o == 4'd8) m_lo = a;
        @(posedge clk);
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cyc++;
            bus.op = junk[$urandom_range(0, 5)]; bus.A = $urandom; bus.B = $urandom; bus.req = 1'($urandom_range(0, 1));
            #1;
            chk("busy_start", 64'(bus.start), 64'd0);
            chk("busy_stall", 64'(bus.stall), 64'd1);
            chk("busy_mul_ce", 64'(bus.mul_ce), 64'(o <= 4'd2));
            chk("busy_div_start", 64'(bus.div_start), 64'd0);
        end
        bus.op = 4'd0; bus.req = 1'b0;
        chk("busy_cycles", 64'(cyc), 64'(lat));
        if (s) {m_hi, m_lo} = res;
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a, b;
        bus.req = 1'b0; bus.op = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_mul_ce", 64'(bus.mul_ce), 64'd0);
        chk("rst_div_start", 64'(bus.div_start), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        do_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        chk("mult_hi", 64'(m_hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(m_lo), 64'hFFFFFFF1);
        do_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        d_dly = 8;
        do_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        chk("div_lo", 64'(m_lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(m_hi), 64'h00000001);
        do_op(4'd7, 32'h12345678, 32'd0, 1'b0);
        do_op(4'd8, 32'h12345678, 32'd0, 1'b0);
        do_op(4'd4, 32'd99, 32'd0, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        do_op(4'd1, 32'd3, 32'd4, 1'b1);
        do_op(4'd7, 32'hCAFEF00D, 32'd0, 1'b1);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom_range(0, 9) == 0 ? 32'd0 : $urandom;
            if (o == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            d_dly = $urandom_range(1, 12);
            do_op(o, a, b, $urandom_range(0, 9) == 0);
            if (k % 4 == 3) begin
                do_op(4'd5, 32'd0, 32'd0, 1'b0);
                do_op(4'd6, 32'd0, 32'd0, 1'b0);
            end
        end
        @(negedge clk);
        bus.op = 4'd1; bus.A = 32'd6; bus.B = 32'd7;
        @(negedge clk);
        bus.op = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_mul_ce", 64'(bus.mul_ce), 64'd0);
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_busy", 64'(bus.busy), 64'd0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
